// File: rtl/ula_arbiter_if.sv
// Request/response/ULA bundle for ula_arbiter.
// slave = arbiter side, master = control unit + ULA side.
interface ula_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             iReq0Valid, oReq0Ready;
  logic [OPW-1:0]   iReq0Op;
  logic [WIDTH-1:0] iReq0A, iReq0B;
  logic             iReq1Valid, oReq1Ready;
  logic [OPW-1:0]   iReq1Op;
  logic [WIDTH-1:0] iReq1A, iReq1B;
  logic             oRspValid, iRspReady, oRspId, oRspZero;
  logic [WIDTH-1:0] oRspResult;
  logic [OPW-1:0]   oUlaControl;
  logic [WIDTH-1:0] oUlaA, oUlaB, iUlaResult;
  logic             iUlaZero;

  modport slave (
    input  iReq0Valid, iReq0Op, iReq0A, iReq0B,
    input  iReq1Valid, iReq1Op, iReq1A, iReq1B,
    input  iRspReady, iUlaResult, iUlaZero,
    output oReq0Ready, oReq1Ready, oRspValid, oRspId, oRspResult, oRspZero,
    output oUlaControl, oUlaA, oUlaB
  );

  modport master (
    output iReq0Valid, iReq0Op, iReq0A, iReq0B,
    output iReq1Valid, iReq1Op, iReq1A, iReq1B,
    output iRspReady, iUlaResult, iUlaZero,
    input  oReq0Ready, oReq1Ready, oRspValid, oRspId, oRspResult, oRspZero,
    input  oUlaControl, oUlaA, oUlaB
  );
endinterface

// File: rtl/ula_arbiter.sv
// Two-requester round-robin arbiter in front of a single combinational ULA.
// Define ULA_ARB_FIXED_PRI_EN to make requester 0 win every tie.
module ula_arbiter #(
  parameter int   WIDTH   = 32,
  parameter int   OPW     = 3,
  parameter logic RR_INIT = 1'b1
) (
  input logic           iCLK,
  input logic           iRST,
  ula_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} stateT;

  stateT            state;
  logic [OPW-1:0]   opReg;
  logic [WIDTH-1:0] aReg, bReg, rspResult;
  logic             rspZero, rspValid, idReg;
  logic             grantId, accept;

`ifdef ULA_ARB_FIXED_PRI_EN
  assign grantId = !bus.iReq0Valid;
`else
  logic lastPtr;
  // On a tie the requester that did not win last time goes next.
  assign grantId = (bus.iReq0Valid && bus.iReq1Valid) ? ~lastPtr : !bus.iReq0Valid;
`endif

  assign accept         = (state == IDLE) && (bus.iReq0Valid || bus.iReq1Valid);
  assign bus.oReq0Ready = accept && !grantId;
  assign bus.oReq1Ready = accept && grantId;

  assign bus.oUlaControl = opReg;
  assign bus.oUlaA       = aReg;
  assign bus.oUlaB       = bReg;
  assign bus.oRspValid   = rspValid;
  assign bus.oRspId      = idReg;
  assign bus.oRspResult  = rspResult;
  assign bus.oRspZero    = rspZero;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      idReg     <= 1'b0;
      rspResult <= '0;
      rspZero   <= 1'b0;
      rspValid  <= 1'b0;
`ifndef ULA_ARB_FIXED_PRI_EN
      lastPtr   <= RR_INIT;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          opReg <= grantId ? bus.iReq1Op : bus.iReq0Op;
          aReg  <= grantId ? bus.iReq1A  : bus.iReq0A;
          bReg  <= grantId ? bus.iReq1B  : bus.iReq0B;
          idReg <= grantId;
`ifndef ULA_ARB_FIXED_PRI_EN
          lastPtr <= grantId;
`endif
          state <= EXEC;
        end
        EXEC: begin
          rspResult <= bus.iUlaResult;
          rspZero   <= bus.iUlaZero;
          rspValid  <= 1'b1;
          state     <= RESP;
        end
        RESP: if (bus.iRspReady) begin
          rspValid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ULA closing the loop.
module tb_ula_arbiter;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] ulaRes;

  ula_arbiter_if #(.WIDTH(32), .OPW(3)) bus ();

  ula_arbiter #(.WIDTH(32), .OPW(3), .RR_INIT(1'b1)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  // Reference ULA: AND,OR,ADD,SUB,SLT,XOR; 6/7 yield zero.
  always_comb begin
    ulaRes = '0;
    case (bus.oUlaControl)
      3'd0: ulaRes = bus.oUlaA & bus.oUlaB;
      3'd1: ulaRes = bus.oUlaA | bus.oUlaB;
      3'd2: ulaRes = bus.oUlaA + bus.oUlaB;
      3'd3: ulaRes = bus.oUlaA - bus.oUlaB;
      3'd4: ulaRes = ($signed(bus.oUlaA) < $signed(bus.oUlaB)) ? 32'd1 : 32'd0;
      3'd5: ulaRes = bus.oUlaA ^ bus.oUlaB;
      default: ulaRes = '0;
    endcase
  end
  assign bus.iUlaResult = ulaRes;
  assign bus.iUlaZero   = (ulaRes == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK); #1;
  endtask

  // Raise valid on requester k, wait (bounded) for ready, hold through the accept edge.
  task automatic issue(input bit k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    if (k) begin
      bus.iReq1Valid = 1'b1; bus.iReq1Op = op; bus.iReq1A = a; bus.iReq1B = b;
    end else begin
      bus.iReq0Valid = 1'b1; bus.iReq0Op = op; bus.iReq0A = a; bus.iReq0B = b;
    end
    #1;
    while (!(k ? bus.oReq1Ready : bus.oReq0Ready) && n < 10) begin
      @(posedge iCLK); #2; n++;
    end
    chk("accept", {31'd0, (k ? bus.oReq1Ready : bus.oReq0Ready)}, 32'd1);
    tick();
    if (k) bus.iReq1Valid = 1'b0; else bus.iReq0Valid = 1'b0;
  endtask

  task automatic waitRsp();
    int n = 0;
    while (!bus.oRspValid && n < 10) begin
      tick(); n++;
    end
    chk("rspValid", {31'd0, bus.oRspValid}, 32'd1);
  endtask

  task automatic checkRsp(input string tag, input logic id, input logic [31:0] res, input logic zero);
    chk({tag, ".id"},     {31'd0, bus.oRspId},   {31'd0, id});
    chk({tag, ".result"}, bus.oRspResult,        res);
    chk({tag, ".zero"},   {31'd0, bus.oRspZero}, {31'd0, zero});
  endtask

  task automatic consume();
    bus.iRspReady = 1'b1;
    tick();
    bus.iRspReady = 1'b0;
  endtask

  initial begin
    logic [31:0] expGrant;
    int n;
    bus.iReq0Valid = 0; bus.iReq0Op = 0; bus.iReq0A = 0; bus.iReq0B = 0;
    bus.iReq1Valid = 0; bus.iReq1Op = 0; bus.iReq1A = 0; bus.iReq1B = 0;
    bus.iRspReady  = 0;

    // Reset state
    tick(); tick();
    chk("rst.rspValid", {31'd0, bus.oRspValid},  32'd0);
    chk("rst.ready0",   {31'd0, bus.oReq0Ready}, 32'd0);
    chk("rst.ulaCtl",   {29'd0, bus.oUlaControl}, 32'd0);
    chk("rst.ulaA",     bus.oUlaA, 32'd0);
    chk("rst.ulaB",     bus.oUlaB, 32'd0);
    iRST = 1'b0;
    tick();

    // 1: ADD 5+7, exact latency
    bus.iReq0Valid = 1; bus.iReq0Op = 3'd2; bus.iReq0A = 32'd5; bus.iReq0B = 32'd7;
    #1;
    chk("t1.ready0", {31'd0, bus.oReq0Ready}, 32'd1);
    chk("t1.ready1", {31'd0, bus.oReq1Ready}, 32'd0);
    tick();
    bus.iReq0Valid = 0;
    chk("t1.exec.rspValid", {31'd0, bus.oRspValid}, 32'd0);
    chk("t1.exec.ready0",   {31'd0, bus.oReq0Ready}, 32'd0);
    chk("t1.exec.ulaCtl",   {29'd0, bus.oUlaControl}, 32'd2);
    chk("t1.exec.ulaA",     bus.oUlaA, 32'd5);
    chk("t1.exec.ulaB",     bus.oUlaB, 32'd7);
    tick();
    chk("t1.rspValid", {31'd0, bus.oRspValid}, 32'd1);
    checkRsp("t1", 1'b0, 32'd12, 1'b0);
    consume();
    chk("t1.rspDone", {31'd0, bus.oRspValid}, 32'd0);

    // 2: SUB 9-9 from requester 1
    issue(1'b1, 3'd3, 32'd9, 32'd9);
    waitRsp();
    checkRsp("t2", 1'b1, 32'd0, 1'b1);
    consume();

    // 3: both valid continuously, response always taken
    bus.iReq0Valid = 1; bus.iReq0Op = 3'd2; bus.iReq0A = 32'd1; bus.iReq0B = 32'd1;
    bus.iReq1Valid = 1; bus.iReq1Op = 3'd2; bus.iReq1A = 32'd2; bus.iReq1B = 32'd2;
    bus.iRspReady  = 1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(bus.oReq0Ready || bus.oReq1Ready) && n < 10) begin
        @(posedge iCLK); #2; n++;
      end
`ifdef ULA_ARB_FIXED_PRI_EN
      expGrant = 32'd0;
`else
      expGrant = (g % 2 == 0) ? 32'd0 : 32'd1;
`endif
      chk("t3.grant", {31'd0, bus.oReq1Ready}, expGrant);
      chk("t3.single", {31'd0, bus.oReq0Ready ^ bus.oReq1Ready}, 32'd1);
      tick();
    end
    bus.iReq0Valid = 0; bus.iReq1Valid = 0;
    tick(); tick(); tick();
    bus.iRspReady = 0;
    chk("t3.drained", {31'd0, bus.oRspValid}, 32'd0);

    // 4: consumer stalls 5 cycles; no accept while held
    issue(1'b0, 3'd1, 32'd3, 32'd4);
    bus.iReq1Valid = 1; bus.iReq1Op = 3'd0; bus.iReq1A = 32'd6; bus.iReq1B = 32'd3;
    waitRsp();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4.hold.valid",  {31'd0, bus.oRspValid},  32'd1);
      chk("t4.hold.result", bus.oRspResult,          32'd7);
      chk("t4.hold.ready0", {31'd0, bus.oReq0Ready}, 32'd0);
      chk("t4.hold.ready1", {31'd0, bus.oReq1Ready}, 32'd0);
      tick();
    end
    consume();
    #1;
    chk("t4.resume.ready1", {31'd0, bus.oReq1Ready}, 32'd1);
    tick();
    bus.iReq1Valid = 0;
    waitRsp();
    checkRsp("t4b", 1'b1, 32'd2, 1'b0);
    consume();

    // 5: SLT signed and XOR
    issue(1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1);
    waitRsp();
    checkRsp("t5.slt", 1'b0, 32'd1, 1'b0);
    consume();
    issue(1'b1, 3'd5, 32'hFFFF_0000, 32'h0F0F_0F0F);
    waitRsp();
    checkRsp("t5.xor", 1'b1, 32'hF0F0_0F0F, 1'b0);
    consume();

    // 6: reset during EXEC drops the op and restores the pointer
    issue(1'b0, 3'd2, 32'd1, 32'd1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("t6.rspValid", {31'd0, bus.oRspValid}, 32'd0);
    chk("t6.ulaA",     bus.oUlaA, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6.noRsp", {31'd0, bus.oRspValid}, 32'd0);
    end
    bus.iReq0Valid = 1; bus.iReq0Op = 3'd2; bus.iReq0A = 32'd2; bus.iReq0B = 32'd3;
    bus.iReq1Valid = 1; bus.iReq1Op = 3'd3; bus.iReq1A = 32'd8; bus.iReq1B = 32'd1;
    #1;
    chk("t6.tie.ready0", {31'd0, bus.oReq0Ready}, 32'd1);
    chk("t6.tie.ready1", {31'd0, bus.oReq1Ready}, 32'd0);
    tick();
    bus.iReq0Valid = 0; bus.iReq1Valid = 0;
    waitRsp();
    checkRsp("t6", 1'b0, 32'd5, 1'b0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
